// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack card path: deck geometry, card encoding,
// LFSR constants, shuffler state encoding and the card point-value helper.
package blackjack_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned CARD_W    = 6;
  localparam int unsigned SUIT_SIZE = 13;

  localparam logic [CARD_W-1:0] LAST_CARD = 6'd51;

  // Card index = suit * SUIT_SIZE + rank
  localparam int unsigned SUIT_CLUBS    = 0;
  localparam int unsigned SUIT_DIAMONDS = 1;
  localparam int unsigned SUIT_HEARTS   = 2;
  localparam int unsigned SUIT_SPADES   = 3;
  localparam int unsigned RANK_ACE      = 0;
  localparam int unsigned RANK_TEN      = 9;
  localparam int unsigned RANK_KING     = 12;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StShuffle,
    StStream,
    StDone
  } state_e;

  // Point value of a card: Ace=1, 2..9 face value, Ten/J/Q/K=10.
  function automatic logic [3:0] card_value(input logic [CARD_W-1:0] idx);
    int unsigned rank;
    rank = idx % SUIT_SIZE;
    if (rank == RANK_ACE) begin
      return 4'd1;
    end else if (rank >= RANK_TEN) begin
      return 4'd10;
    end else begin
      return 4'(rank + 1);
    end
  endfunction

  // Smallest all-ones mask covering 0..i, so rejection sampling accepts >= 50%.
  function automatic logic [CARD_W-1:0] shuffle_mask(input logic [CARD_W-1:0] i);
    if (i >= 6'd32) begin
      return 6'd63;
    end else if (i >= 6'd16) begin
      return 6'd31;
    end else if (i >= 6'd8) begin
      return 6'd15;
    end else if (i >= 6'd4) begin
      return 6'd7;
    end else if (i >= 6'd2) begin
      return 6'd3;
    end else begin
      return 6'd1;
    end
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR; free-running except on reset or load.
module lfsr16_galois
  import blackjack_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/deck_shuffler.sv
// Builds a 52-card deck, Fisher-Yates shuffles it in place from an LFSR and
// streams the resulting permutation over a valid/ready handshake.
module deck_shuffler
  import blackjack_pkg::*;
#(
  parameter bit          SHUFFLE_EN = 1'b1,
  parameter logic [15:0] SEED       = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  input  logic              card_ready,
  output logic [CARD_W-1:0] card,
  output logic              card_valid,
  output logic              load_flag,
  output logic              busy,
  output logic [CARD_W-1:0] remaining,
  output logic              done
);

  state_e            state_q, state_d;
  logic [CARD_W-1:0] deck_q [DECK_SIZE];
  logic [CARD_W-1:0] ptr_q;        // INIT write index, then STREAM read index
  logic [CARD_W-1:0] i_q;
  logic [CARD_W-1:0] remaining_q;
  logic [15:0]       lfsr_q;
  logic              lfsr_load;
  logic [15:0]       lfsr_load_val;
  logic [CARD_W-1:0] r;
  logic              accept;
  logic              xfer;
  logic              unused_lfsr;

  assign lfsr_load     = (state_q == StIdle) && seed_load;
  assign lfsr_load_val = (seed == 16'h0000) ? DEFAULT_SEED : seed;

  lfsr16_galois #(
    .RESET_VAL (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:CARD_W];
  assign r           = lfsr_q[CARD_W-1:0] & shuffle_mask(i_q);
  assign accept      = (r <= i_q);
  assign xfer        = (state_q == StStream) && card_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) state_d = StInit;
      end
      StInit: begin
        if (ptr_q == LAST_CARD) state_d = SHUFFLE_EN ? StShuffle : StStream;
      end
      StShuffle: begin
        if (accept && (i_q == 6'd1)) state_d = StStream;
      end
      StStream: begin
        if (xfer && (ptr_q == LAST_CARD)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      i_q         <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle, StDone: begin
          if (start) ptr_q <= '0;
        end
        StInit: begin
          ptr_q <= ptr_q + 6'd1;
          i_q   <= LAST_CARD;
        end
        StShuffle: begin
          if (accept) i_q <= i_q - 6'd1;
        end
        StStream: begin
          if (xfer) begin
            ptr_q       <= ptr_q + 6'd1;
            remaining_q <= remaining_q - 6'd1;
          end
        end
        default: ;
      endcase
      if ((state_d == StStream) && (state_q != StStream)) begin
        ptr_q       <= '0;
        remaining_q <= CARD_W'(DECK_SIZE);
      end
    end
  end

  // Deck storage is deliberately unreset; INIT always rewrites every entry.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      deck_q[ptr_q] <= ptr_q;
    end else if ((state_q == StShuffle) && accept) begin
      deck_q[i_q] <= deck_q[r];
      deck_q[r]   <= deck_q[i_q];
    end
  end

  always_comb begin
    card_valid = (state_q == StStream);
    card       = card_valid ? deck_q[ptr_q] : '0;
    load_flag  = (state_q == StStream);
    busy       = (state_q == StInit) || (state_q == StShuffle);
    done       = (state_q == StDone);
    remaining  = remaining_q;
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// Scoreboard bench: in-order instance checked against queued 0..51 vectors,
// shuffling instance checked for permutation, determinism and seed sensitivity.
module tb_deck_shuffler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, start0, seed_load0, card_ready0;
  logic [15:0] seed0;
  logic [5:0] card0, remaining0;
  logic       card_valid0, load_flag0, busy0, done0;

  logic       rst1, start1, seed_load1, card_ready1;
  logic [15:0] seed1;
  logic [5:0] card1, remaining1;
  logic       card_valid1, load_flag1, busy1, done1;

  deck_shuffler #(
    .SHUFFLE_EN (1'b0),
    .SEED       (16'hACE1)
  ) dut0 (
    .clk        (clk),
    .rst        (rst0),
    .start      (start0),
    .seed_load  (seed_load0),
    .seed       (seed0),
    .card_ready (card_ready0),
    .card       (card0),
    .card_valid (card_valid0),
    .load_flag  (load_flag0),
    .busy       (busy0),
    .remaining  (remaining0),
    .done       (done0)
  );

  deck_shuffler #(
    .SHUFFLE_EN (1'b1),
    .SEED       (16'hACE1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst1),
    .start      (start1),
    .seed_load  (seed_load1),
    .seed       (seed1),
    .card_ready (card_ready1),
    .card       (card1),
    .card_valid (card_valid1),
    .load_flag  (load_flag1),
    .busy       (busy1),
    .remaining  (remaining1),
    .done       (done1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int exp_card0[$];
  int exp_rem0[$];
  int exp_rem1[$];
  int cap1[$];
  int seq_a[52], seq_b[52], seq_c[52], seq_d[52], seq_e[52];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the in-order instance
  always @(negedge clk) begin
    if (rst0 && card_valid0 && card_ready0) begin
      if (exp_card0.size() == 0) begin
        check("dut0_extra_card", int'(card0), -1);
      end else begin
        check("dut0_card", int'(card0), exp_card0.pop_front());
        check("dut0_remaining", int'(remaining0), exp_rem0.pop_front());
      end
    end
  end

  // Monitor for the shuffling instance
  always @(negedge clk) begin
    if (rst1 && card_valid1 && card_ready1) begin
      cap1.push_back(int'(card1));
      check("dut1_busy_while_valid", int'(busy1), 0);
      check("dut1_load_flag", int'(load_flag1), 1);
      if (exp_rem1.size() == 0) begin
        check("dut1_extra_card", int'(card1), -1);
      end else begin
        check("dut1_remaining", int'(remaining1), exp_rem1.pop_front());
      end
    end
  end

  task automatic push_in_order();
    for (int n = 0; n < 52; n++) begin
      exp_card0.push_back(n);
      exp_rem0.push_back(52 - n);
    end
  endtask

  task automatic wait_done0(input string tag);
    int t = 0;
    while (!done0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_done"}, int'(done0), 1);
    check({tag, "_queue_drained"}, exp_card0.size(), 0);
    check({tag, "_load_flag_low"}, int'(load_flag0), 0);
    check({tag, "_remaining_zero"}, int'(remaining0), 0);
    check({tag, "_valid_low"}, int'(card_valid0), 0);
  endtask

  task automatic reset1();
    @(posedge clk); #1;
    rst1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b1;
  endtask

  // Runs one shuffle on dut1; poke pulses start during SHUFFLE and STREAM.
  task automatic run1(input logic [15:0] s, input bit use_seed, input bit poke);
    int t;
    cap1.delete();
    exp_rem1.delete();
    for (int n = 52; n >= 1; n--) exp_rem1.push_back(n);
    card_ready1 = 1'b1;
    @(posedge clk); #1;
    seed1 = s; seed_load1 = use_seed; start1 = 1'b1;
    @(posedge clk); #1;
    seed_load1 = 1'b0; start1 = 1'b0;
    check("dut1_busy_after_start", int'(busy1), 1);
    check("dut1_done_cleared", int'(done1), 0);
    if (poke) begin
      repeat (58) @(posedge clk);
      #1;
      check("dut1_busy_in_shuffle", int'(busy1), 1);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      t = 0;
      while (!card_valid1 && t < 2000) begin
        @(posedge clk); #1;
        t++;
      end
      check("dut1_stream_reached", int'(card_valid1), 1);
      repeat (3) @(posedge clk);
      #1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    t = 0;
    while (!done1 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("dut1_done_reached", int'(done1), 1);
    check("dut1_stream_len", cap1.size(), 52);
    check("dut1_remaining_zero", int'(remaining1), 0);
  endtask

  task automatic check_perm(input string tag);
    bit seen[52];
    int bad = 0, dups = 0, moved = 0;
    foreach (seen[n]) seen[n] = 1'b0;
    foreach (cap1[n]) begin
      if (cap1[n] < 0 || cap1[n] > 51) bad++;
      else if (seen[cap1[n]]) dups++;
      else seen[cap1[n]] = 1'b1;
      if (cap1[n] != n) moved++;
    end
    check({tag, "_out_of_range"}, bad, 0);
    check({tag, "_duplicates"}, dups, 0);
    check({tag, "_not_identity"}, int'(moved > 0), 1);
  endtask

  task automatic save(output int s[52]);
    for (int n = 0; n < 52; n++) s[n] = (n < cap1.size()) ? cap1[n] : -1;
  endtask

  function automatic int ndiff(input int a[52], input int b[52]);
    int d = 0;
    for (int n = 0; n < 52; n++) if (a[n] != b[n]) d++;
    return d;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0; start0 = 1'b0; seed_load0 = 1'b0; seed0 = '0; card_ready0 = 1'b0;
    rst1 = 1'b0; start1 = 1'b0; seed_load1 = 1'b0; seed1 = '0; card_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b1; rst1 = 1'b1;

    check("rst1_card_valid", int'(card_valid1), 0);
    check("rst1_busy", int'(busy1), 0);
    check("rst1_done", int'(done1), 0);
    check("rst1_remaining", int'(remaining1), 0);
    check("rst1_card", int'(card1), 0);

    // Reset held for two cycles in the middle of a stalled stream
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("dut0_busy_in_init", int'(busy0), 1);
    repeat (60) @(posedge clk);
    #1;
    check("dut0_stalled_valid", int'(card_valid0), 1);
    check("dut0_stalled_remaining", int'(remaining0), 52);
    rst0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst0_card_valid", int'(card_valid0), 0);
    check("rst0_busy", int'(busy0), 0);
    check("rst0_load_flag", int'(load_flag0), 0);
    check("rst0_remaining", int'(remaining0), 0);
    check("rst0_done", int'(done0), 0);
    check("rst0_card", int'(card0), 0);
    rst0 = 1'b1;

    // In-order stream and start-to-valid latency
    card_ready0 = 1'b1;
    push_in_order();
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (51) @(posedge clk);
    #1;
    check("dut0_valid_after_52", int'(card_valid0), 0);
    @(posedge clk); #1;
    check("dut0_valid_after_53", int'(card_valid0), 1);
    check("dut0_load_flag_stream", int'(load_flag0), 1);
    wait_done0("dut0_inorder");

    // Start from DONE, then backpressure after the 5th transfer
    push_in_order();
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check("dut0_done_cleared", int'(done0), 0);
    begin
      int t = 0;
      while (exp_card0.size() > 47 && t < 500) begin
        @(negedge clk); #1;
        t++;
      end
      check("dut0_five_transfers", exp_card0.size(), 47);
    end
    @(posedge clk); #1;
    card_ready0 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_card_held", int'(card0), 5);
      check("bp_remaining_held", int'(remaining0), 47);
      check("bp_valid_held", int'(card_valid0), 1);
    end
    @(posedge clk); #1;
    card_ready0 = 1'b1;
    wait_done0("dut0_backpressure");

    // Seeded shuffles: permutation, determinism, seed sensitivity, 0 -> ACE1
    reset1();
    run1(16'hACE1, 1'b1, 1'b0);
    check_perm("seed_ace1");
    save(seq_a);
    reset1();
    run1(16'h1234, 1'b1, 1'b0);
    check_perm("seed_1234_a");
    save(seq_b);
    reset1();
    run1(16'h1234, 1'b1, 1'b0);
    save(seq_c);
    check("seed_1234_repeatable", ndiff(seq_b, seq_c), 0);
    check("seed_ace1_vs_1234_differ", int'(ndiff(seq_a, seq_b) > 0), 1);
    reset1();
    run1(16'h0000, 1'b1, 1'b0);
    save(seq_d);
    check("seed_zero_maps_ace1", ndiff(seq_a, seq_d), 0);

    // start pulses during SHUFFLE and STREAM must not perturb the sequence
    reset1();
    run1(16'h1234, 1'b1, 1'b1);
    save(seq_e);
    check("start_ignored_mid_run", ndiff(seq_b, seq_e), 0);

    // One-cycle reset mid-SHUFFLE, then fresh shuffles incl. start from DONE
    reset1();
    card_ready1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("dut1_busy_before_abort", int'(busy1), 1);
    rst1 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b1;
    check("abort_busy", int'(busy1), 0);
    check("abort_valid", int'(card_valid1), 0);
    check("abort_done", int'(done1), 0);
    check("abort_remaining", int'(remaining1), 0);
    run1(16'h0000, 1'b0, 1'b0);
    check_perm("after_abort");
    run1(16'h0000, 1'b0, 1'b0);
    check_perm("from_done");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deck_shuffler.md
Name: deck_shuffler

Overview:
Upstream card source for the blackjack controller. On request it initialises a 52-card deck, performs an in-place Fisher-Yates shuffle driven by an internal 16-bit LFSR, then streams the shuffled card indices to the controller over a valid/ready handshake. It supplies all card traffic consumed during the controller's load phase.

Parameters:
SHUFFLE_EN, 1, 0 = skip the shuffle and stream 0..51 in order (bring-up/test)
SEED, 16'hACE1, LFSR value loaded at reset; must be non-zero

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  begin a new shuffle; sampled only in IDLE or DONE
seed_load  in  1  in IDLE, load LFSR from seed (0 maps to 16'hACE1)
seed  in  16  reseed value
card_ready  in  1  consumer accepts card this cycle
card  out  6  card index 0..51 (suit*13 + rank, rank 0=Ace .. 12=King)
card_valid  out  1  card holds a valid deck entry
load_flag  out  1  high throughout STREAM
busy  out  1  high in INIT and SHUFFLE
remaining  out  6  cards not yet transferred
done  out  1  high in DONE until next start

Behaviour:
- Reset (rst=0 at edge): state=IDLE, card=0, card_valid=0, load_flag=0, busy=0, remaining=0, done=0, LFSR=SEED, deck contents don't-care. Reset has priority over every other input, in every state.
- LFSR: 16-bit Galois, taps 0xB400, advances every cycle in every state except reset, so start timing adds entropy. Never zero.
- States: IDLE, INIT, SHUFFLE, STREAM, DONE.
- IDLE/DONE: start=1 -> INIT, clear done, set k=0. seed_load is honoured only in IDLE; if seed_load and start are both high, the seed is loaded and the shuffle starts from the new seed.
- INIT: write deck[k]=k, k=0..51, one entry per cycle (52 cycles). After k=51 -> SHUFFLE if SHUFFLE_EN, else STREAM. Set i=51.
- SHUFFLE: each cycle r = lfsr[5:0] & mask(i), where mask(i) = 2^ceil(log2(i+1)) - 1.
  - If r <= i: swap deck[i] and deck[r] in the same cycle (register array), then i = i-1.
  - If r > i: retry next cycle with no swap.
  - After the i=1 swap -> STREAM.
  - Acceptance per cycle is at least 50%, so no timeout is required.
- On entry to STREAM: idx=0, remaining=52.
- STREAM:
  - card_valid=1, card=deck[idx].
  - Transfer occurs when card_valid and card_ready: idx+1, remaining-1.
  - card and remaining stay stable while card_ready=0.
  - The transfer at idx=51 -> DONE, card_valid=0, load_flag=0, remaining=0, done=1.
- start is ignored in INIT, SHUFFLE and STREAM.
- Latency: with SHUFFLE_EN=0, card_valid rises 53 edges after the edge that samples start (1 edge to enter INIT plus 52 INIT writes). With SHUFFLE_EN=1 there are at least 51 additional cycles (variable because of rejection).
- Output is always a permutation of 0..51; no value >= 52 is ever presented.

Decomposition:
- Shared package blackjack_pkg:
  - DECK_SIZE=52, CARD_W=6, SUIT_SIZE=13
  - card-index encoding constants
  - LFSR_TAPS=16'hB400, DEFAULT_SEED=16'hACE1
  - card_value function (index -> 1..10, Ace=1), shared with the controller
  - state encoding localparams
- One sub-module: lfsr16_galois (clk, rst, load, load_val, q).

Test Plan:
1. Hold rst=0 for 2 cycles mid-operation -> card_valid=0, busy=0, load_flag=0, remaining=0, done=0, card=0.
2. SHUFFLE_EN=0, card_ready=1, pulse start -> card_valid rises 53 edges later; card = 0,1,...,51 on consecutive cycles; remaining 52->1; then done=1 and load_flag=0.
3. SHUFFLE_EN=1, SEED=16'hACE1, card_ready=1 -> 52 transfers, each of 0..51 exactly once, order differs from 0..51; busy=0 before the first card_valid.
4. Reload seed 16'h1234 twice via seed_load with identical start timing -> identical sequences; seed 16'hACE1 vs 16'h1234 -> different sequences.
5. Backpressure: drop card_ready for 10 cycles after the 5th transfer -> card value held, remaining=47 held, card_valid stays 1; resumes with no loss or duplicate.
6. start pulsed during SHUFFLE and during STREAM -> ignored. rst=0 for 1 cycle mid-SHUFFLE -> IDLE; a new start yields a full valid permutation. start in DONE -> done clears and a new shuffle begins.
